// File: rtl/text_write_ctrl.sv
// Character-stream write sequencer for the text display buffer: owns the cursor,
// turns ASCII codes into single-cell writes, and clears the grid after reset.
module text_write_ctrl #(
    parameter int         GRID_COL      = 10,
    parameter int         GRID_ROW      = 5,
    parameter int         ADDR_W        = $clog2(GRID_COL * GRID_ROW),
    parameter logic [6:0] CURSOR_CODE   = 7'd127,
    parameter logic [7:0] DEFAULT_COLOR = 8'h15
) (
    input  logic              clk_pix,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [6:0]        in_ascii,
    input  logic [3:0]        color_f,
    input  logic [3:0]        color_b,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [15:0]       wr_data,
    output logic [ADDR_W-1:0] cur_pos,
    output logic              busy
);

    localparam int COL_W = (GRID_COL > 1) ? $clog2(GRID_COL) : 1;
    localparam int ROW_W = (GRID_ROW > 1) ? $clog2(GRID_ROW) : 1;

    localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(GRID_COL - 1);
    localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(GRID_ROW - 1);
    localparam logic [ADDR_W-1:0] CELL_LAST = ADDR_W'(GRID_COL * GRID_ROW - 1);

    localparam logic [6:0] CODE_NL    = 7'h0A;
    localparam logic [6:0] CODE_BS    = 7'h08;
    localparam logic [6:0] CODE_CLEAR = 7'h0C;
    localparam logic [6:0] CODE_BLANK = 7'h00;

    typedef enum logic [2:0] {
        S_START,
        S_CLEAR,
        S_WRITE,
        S_CURSOR,
        S_IDLE
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
    logic [COL_W-1:0]  col_q, col_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic [ADDR_W-1:0] pos_q, pos_d;
    logic [6:0]        code_q, code_d;
    logic [7:0]        color_q, color_d;

    function automatic logic is_printable(input logic [6:0] c);
        return (c >= 7'h20) && (c <= 7'h7E);
    endfunction

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of every other flop, independent of process order.
    always_ff @(posedge clk_pix or posedge rst) begin
        if (rst) begin
            state_q   <= S_START;
            clr_cnt_q <= '0;
            col_q     <= '0;
            row_q     <= '0;
            pos_q     <= '0;
            code_q    <= '0;
            color_q   <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            col_q     <= col_d;
            row_q     <= row_d;
            pos_q     <= pos_d;
            code_q    <= code_d;
            color_q   <= color_d;
        end
    end

    // NOTE: every signal assigned in this block gets a default first, so no
    // path through the case statement can leave a latch behind.
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        col_d     = col_q;
        row_d     = row_q;
        code_d    = code_q;
        color_d   = color_q;
        wr_en     = 1'b0;
        wr_addr   = '0;
        wr_data   = '0;

        case (state_q)
            S_START: begin
                clr_cnt_d = '0;
                color_d   = DEFAULT_COLOR;
                state_d   = S_CLEAR;
            end

            S_CLEAR: begin
                wr_en     = 1'b1;
                wr_addr   = clr_cnt_q;
                wr_data   = {color_q, 1'b1, CODE_BLANK};
                clr_cnt_d = clr_cnt_q + 1'b1;
                if (clr_cnt_q == CELL_LAST) begin
                    col_d   = '0;
                    row_d   = '0;
                    state_d = S_CURSOR;
                end
            end

            S_IDLE: begin
                if (in_valid) begin
                    code_d  = in_ascii;
                    color_d = {color_f, color_b};
                    if (is_printable(in_ascii) || in_ascii == CODE_NL || in_ascii == CODE_BS) begin
                        state_d = S_WRITE;
                    end else if (in_ascii == CODE_CLEAR) begin
                        clr_cnt_d = '0;
                        state_d   = S_CLEAR;
                    end
                end
            end

            S_WRITE: begin
                wr_en   = 1'b1;
                wr_addr = pos_q;
                wr_data = {color_q, 1'b1, is_printable(code_q) ? code_q : CODE_BLANK};
                state_d = S_CURSOR;
                if (is_printable(code_q)) begin
                    if (col_q == COL_LAST) begin
                        col_d = '0;
                        row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                end else if (code_q == CODE_NL) begin
                    col_d = '0;
                    row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
                end else if (col_q != '0) begin
                    col_d = col_q - 1'b1;
                end else if (row_q != '0) begin
                    // Backspace at column 0 climbs to the end of the previous row;
                    // at cell 0 the cursor simply stays put.
                    col_d = COL_LAST;
                    row_d = row_q - 1'b1;
                end
            end

            S_CURSOR: begin
                wr_en   = 1'b1;
                wr_addr = pos_q;
                wr_data = {color_q, 1'b1, CURSOR_CODE};
                state_d = S_IDLE;
            end

            default: state_d = S_START;
        endcase

        // Deriving the linear position from row/col keeps the three in lockstep.
        pos_d = ADDR_W'(row_d) * ADDR_W'(GRID_COL) + ADDR_W'(col_d);
    end

    assign in_ready = (state_q == S_IDLE);
    assign busy     = (state_q != S_IDLE);
    assign cur_pos  = pos_q;

endmodule

// File: tb/tb_text_write_ctrl.sv
// Scoreboard bench for text_write_ctrl: a linear-position cursor model queues the
// expected buffer writes, and a negedge monitor pops and compares each one.
module tb_text_write_ctrl;

    localparam int         GRID_COL = 10;
    localparam int         GRID_ROW = 5;
    localparam int         CELLS    = GRID_COL * GRID_ROW;
    localparam int         ADDR_W   = $clog2(CELLS);
    localparam logic [6:0] CURSOR   = 7'd127;

    logic              clk_pix  = 1'b0;
    logic              rst      = 1'b1;
    logic              in_valid = 1'b0;
    logic [6:0]        in_ascii = '0;
    logic [3:0]        color_f  = '0;
    logic [3:0]        color_b  = '0;
    logic              in_ready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [15:0]       wr_data;
    logic [ADDR_W-1:0] cur_pos;
    logic              busy;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          n_wr     = 0;
    int          m_pos    = 0;
    logic [31:0] exp_q[$];

    text_write_ctrl dut (
        .clk_pix  (clk_pix),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_ascii (in_ascii),
        .color_f  (color_f),
        .color_b  (color_b),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .cur_pos  (cur_pos),
        .busy     (busy)
    );

    always #5 clk_pix = ~clk_pix;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [15:0] word(input logic [3:0] f, input logic [3:0] b, input logic [6:0] c);
        return {f, b, 1'b1, c};
    endfunction

    task automatic push_wr(input int addr, input logic [15:0] data);
        exp_q.push_back({10'b0, ADDR_W'(addr), data});
    endtask

    always @(negedge clk_pix) begin
        if (!rst && wr_en) begin
            n_wr++;
            if (exp_q.size() == 0)
                check("sb_nonempty", 32'(exp_q.size()), 32'd1);
            else
                check("wr", {10'b0, wr_addr, wr_data}, exp_q.pop_front());
        end
    end

    task automatic tick();
        @(posedge clk_pix);
        #1;
    endtask

    task automatic wait_ready(input string tag, output int cycles);
        cycles = 0;
        while (!in_ready && cycles < 200) begin
            tick();
            cycles++;
        end
        check(tag, 32'(in_ready), 32'd1);
    endtask

    task automatic push_clear(input logic [3:0] f, input logic [3:0] b);
        for (int i = 0; i < CELLS; i++) push_wr(i, word(f, b, 7'h00));
        push_wr(0, word(f, b, CURSOR));
        m_pos = 0;
    endtask

    task automatic send(input logic [6:0] code, input logic [3:0] f, input logic [3:0] b);
        int  cyc;
        bit  is_wr;
        is_wr = 1'b1;
        wait_ready("ready_before_send", cyc);
        if (code >= 7'h20 && code <= 7'h7E) begin
            push_wr(m_pos, word(f, b, code));
            m_pos = (m_pos + 1) % CELLS;
            push_wr(m_pos, word(f, b, CURSOR));
        end else if (code == 7'h0A) begin
            push_wr(m_pos, word(f, b, 7'h00));
            m_pos = ((m_pos / GRID_COL + 1) % GRID_ROW) * GRID_COL;
            push_wr(m_pos, word(f, b, CURSOR));
        end else if (code == 7'h08) begin
            push_wr(m_pos, word(f, b, 7'h00));
            m_pos = (m_pos == 0) ? 0 : m_pos - 1;
            push_wr(m_pos, word(f, b, CURSOR));
        end else if (code == 7'h0C) begin
            push_clear(f, b);
            is_wr = 1'b0;
        end else begin
            is_wr = 1'b0;
        end

        in_valid = 1'b1;
        in_ascii = code;
        color_f  = f;
        color_b  = b;
        tick();
        in_valid = 1'b0;

        if (is_wr) begin
            check("ready_low_e1", 32'(in_ready), 32'd0);
            check("busy_e1", 32'(busy), 32'd1);
            tick();
            check("ready_low_e2", 32'(in_ready), 32'd0);
            tick();
            check("ready_high_e3", 32'(in_ready), 32'd1);
            check("cur_pos", 32'(cur_pos), 32'(m_pos));
        end else if (code == 7'h0C) begin
            wait_ready("clear_done", cyc);
            check("clear_cycles", 32'(cyc), 32'(CELLS + 1));
            check("clear_cur_pos", 32'(cur_pos), 32'd0);
        end else begin
            check("drop_ready", 32'(in_ready), 32'd1);
            check("drop_busy", 32'(busy), 32'd0);
        end
        check("sb_drain", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_wr_en"}, 32'(wr_en), 32'd0);
        check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd1);
        check({tag, "_wr_addr"}, 32'(wr_addr), 32'd0);
        check({tag, "_wr_data"}, 32'(wr_data), 32'd0);
        check({tag, "_cur_pos"}, 32'(cur_pos), 32'd0);
    endtask

    task automatic release_and_clear(input string tag);
        int n0;
        int cyc;
        push_clear(4'h1, 4'h5);
        n0  = n_wr;
        rst = 1'b0;
        check_reset_outputs({tag, "_start"});
        wait_ready({tag, "_ready"}, cyc);
        check({tag, "_latency"}, 32'(cyc), 32'(CELLS + 2));
        check({tag, "_writes"}, 32'(n_wr - n0), 32'(CELLS + 1));
        check({tag, "_cur_pos"}, 32'(cur_pos), 32'd0);
        check({tag, "_drain"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int guard;

        tick();
        tick();
        check_reset_outputs("rst_hold");
        release_and_clear("boot");

        send(7'h41, 4'h2, 4'h3);
        for (int i = 0; i < 12; i++)
            send(7'($urandom_range(32, 126)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
        send(7'h0A, 4'h6, 4'h1);
        for (int i = 0; i < 29; i++)
            send(7'($urandom_range(32, 126)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
        send(7'h5A, 4'h7, 4'h0);

        send(7'h08, 4'h3, 4'h9);
        send(7'h0A, 4'h2, 4'h2);
        send(7'h08, 4'hA, 4'hB);
        for (int i = 0; i < 5; i++) send(7'h0A, 4'hC, 4'hD);

        send(7'h01, 4'hE, 4'hF);
        send(7'h42, 4'h8, 4'h8);
        send(7'h0C, 4'h4, 4'h5);

        push_clear(4'h6, 4'h7);
        in_valid = 1'b1;
        in_ascii = 7'h0C;
        color_f  = 4'h6;
        color_b  = 4'h7;
        tick();
        in_valid = 1'b0;
        guard = 0;
        while (!(wr_en && wr_addr == ADDR_W'(19)) && guard < 100) begin
            tick();
            guard++;
        end
        check("clr20_reached", {31'b0, wr_en}, 32'd1);
        #1 rst = 1'b1;
        #1 check_reset_outputs("rst_async");
        exp_q.delete();
        m_pos = 0;
        tick();
        tick();
        check_reset_outputs("rst_mid_hold");
        release_and_clear("reboot");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
